alu_exu_q: RTL and testbench

- Parametrised successor to the single-entry ALU execution unit.
- Accepts issued ops from the reservation station, computes the integer ALU or branch-compare result in one cycle, and queues {tag, result} in a DEPTH-entry result FIFO.
- The FIFO is drained by the CDB arbiter.
- Adds configurable data/tag width, configurable buffering depth, compare-mode ops, and a flush that squashes all in-flight results.

---
 rtl/alu_exu_q_pkg.sv | 24 ++
 rtl/alu_exu_q_if.sv | 35 +++
 rtl/alu_exu_q_res_fifo.sv | 51 +++++
 rtl/alu_exu_q.sv | 83 ++++++++
 tb/tb_alu_exu_q.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exu_q_pkg.sv
// Shared opcode definitions for the integer execution unit.
// ALU codes 0-9 keep their historical values; codes 10-15 are branch compares.
package rv32i_types;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_SLL  = 4'd2,
    ALU_OP_SLT  = 4'd3,
    ALU_OP_SLTU = 4'd4,
    ALU_OP_XOR  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SRA  = 4'd7,
    ALU_OP_OR   = 4'd8,
    ALU_OP_AND  = 4'd9,
    BR_OP_BEQ   = 4'd10,
    BR_OP_BNE   = 4'd11,
    BR_OP_BLT   = 4'd12,
    BR_OP_BGE   = 4'd13,
    BR_OP_BLTU  = 4'd14,
    BR_OP_BGEU  = 4'd15
  } exu_opc_t;

endpackage

// File: rtl/alu_exu_q_if.sv
// Issue/CDB bus of the ALU execution unit: RS issue side, CDB drain side, flush.
// master = RS/CDB environment, slave = the execution unit.
interface alu_exu_q_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 2
);
  import rv32i_types::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_req;
  logic             in_rdy;
  exu_opc_t         in_opc;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_req;
  logic             out_rdy;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_wdata;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_req, in_opc, in_src1, in_src2, in_tag, out_rdy,
    input  in_rdy, out_req, out_tag, out_wdata, count
  );

  modport slave (
    input  flush, in_req, in_opc, in_src1, in_src2, in_tag, out_rdy,
    output in_rdy, out_req, out_tag, out_wdata, count
  );

endinterface

// File: rtl/alu_exu_q_res_fifo.sv
// Generic DEPTH x W result FIFO with occupancy count, simultaneous push/pop,
// synchronous clear and asynchronous active-low reset. DEPTH need not be 2^n.
module exu_res_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wdata;
        tail      <= ptr_next(tail);
      end
      if (pop) head <= ptr_next(head);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign rdata = mem[head];

endmodule

// File: rtl/alu_exu_q.sv
// Integer ALU / branch-compare execution unit: single-cycle compute, results
// queued as {tag, result} in a DEPTH-entry FIFO drained by the CDB arbiter.
module alu_exu_q
  import rv32i_types::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  alu_exu_q_if.slave   bus
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned SHW = $clog2(XLEN);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  wdata;
  } exu_result_t;

  exu_result_t     wr_ent;
  exu_result_t     rd_ent;
  logic [XLEN-1:0] result;
  logic [SHW-1:0]  shamt;
  logic [CW-1:0]   occ;
  logic            push;
  logic            pop;

  assign shamt = bus.in_src2[SHW-1:0];

  always_comb begin
    result = '0;
    unique case (bus.in_opc)
      ALU_OP_ADD:  result = bus.in_src1 + bus.in_src2;
      ALU_OP_SUB:  result = bus.in_src1 - bus.in_src2;
      ALU_OP_SLL:  result = bus.in_src1 << shamt;
      ALU_OP_SLT:  result = XLEN'($signed(bus.in_src1) < $signed(bus.in_src2));
      ALU_OP_SLTU: result = XLEN'(bus.in_src1 < bus.in_src2);
      ALU_OP_XOR:  result = bus.in_src1 ^ bus.in_src2;
      ALU_OP_SRL:  result = bus.in_src1 >> shamt;
      ALU_OP_SRA:  result = XLEN'($signed(bus.in_src1) >>> shamt);
      ALU_OP_OR:   result = bus.in_src1 | bus.in_src2;
      ALU_OP_AND:  result = bus.in_src1 & bus.in_src2;
      BR_OP_BEQ:   result = XLEN'(bus.in_src1 == bus.in_src2);
      BR_OP_BNE:   result = XLEN'(bus.in_src1 != bus.in_src2);
      BR_OP_BLT:   result = XLEN'($signed(bus.in_src1) < $signed(bus.in_src2));
      BR_OP_BGE:   result = XLEN'($signed(bus.in_src1) >= $signed(bus.in_src2));
      BR_OP_BLTU:  result = XLEN'(bus.in_src1 < bus.in_src2);
      BR_OP_BGEU:  result = XLEN'(bus.in_src1 >= bus.in_src2);
      default:     result = '0;
    endcase
  end

  // Full FIFO still accepts when the head is leaving in the same cycle.
  assign bus.in_rdy  = ((occ != CW'(DEPTH)) | (bus.out_rdy & (occ != '0))) & ~bus.flush;
  assign bus.out_req = (occ != '0) & ~bus.flush;
  assign push        = bus.in_req & bus.in_rdy;
  assign pop         = bus.out_req & bus.out_rdy;

  assign wr_ent.tag   = bus.in_tag;
  assign wr_ent.wdata = result;

  exu_res_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(exu_result_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .clear (bus.flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_ent),
    .rdata (rd_ent),
    .count (occ)
  );

  assign bus.out_tag   = rd_ent.tag;
  assign bus.out_wdata = rd_ent.wdata;
  assign bus.count     = occ;

endmodule

// File: tb/tb_alu_exu_q.sv
// Bench for alu_exu_q: opcode vector table, directed handshake/flush/reset
// sequences on a DEPTH=2 unit, and scoreboarded random streaming on DEPTH=3.
module tb_alu_exu_q;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exu_q_if #(.XLEN(32), .TAG_W(4), .DEPTH(2)) bus ();
  alu_exu_q_if #(.XLEN(32), .TAG_W(4), .DEPTH(3)) bus3 ();

  alu_exu_q #(.XLEN(32), .TAG_W(4), .DEPTH(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
  alu_exu_q #(.XLEN(32), .TAG_W(4), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    exu_opc_t    opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] wdata;
  } ent_t;

  vec_t vecs[18];
  ent_t sb[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference written independently of the RTL (bias-flip signed compare, sign-extended shift).
  function automatic logic [31:0] ref_alu(input exu_opc_t op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  sh;
    logic [63:0] ext;
    logic        lts, ltu, eq;
    sh  = b[4:0];
    ext = {{32{a[31]}}, a} >> sh;
    ltu = a < b;
    lts = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    eq  = (a == b);
    case (op)
      ALU_OP_ADD:  return a + b;
      ALU_OP_SUB:  return a + ~b + 32'd1;
      ALU_OP_SLL:  return a << sh;
      ALU_OP_SLT:  return {31'd0, lts};
      ALU_OP_SLTU: return {31'd0, ltu};
      ALU_OP_XOR:  return a ^ b;
      ALU_OP_SRL:  return a >> sh;
      ALU_OP_SRA:  return ext[31:0];
      ALU_OP_OR:   return a | b;
      ALU_OP_AND:  return a & b;
      BR_OP_BEQ:   return {31'd0, eq};
      BR_OP_BNE:   return {31'd0, !eq};
      BR_OP_BLT:   return {31'd0, lts};
      BR_OP_BGE:   return {31'd0, !lts};
      BR_OP_BLTU:  return {31'd0, ltu};
      default:     return {31'd0, !ltu};
    endcase
  endfunction

  task automatic drive(input exu_opc_t op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    bus.in_req  = 1'b1;
    bus.in_opc  = op;
    bus.in_src1 = a;
    bus.in_src2 = b;
    bus.in_tag  = t;
  endtask

  initial begin
    vecs[0]  = '{ALU_OP_ADD,  32'hFFFF_FFFF, 32'd1,         4'd3,  32'h0000_0000};
    vecs[1]  = '{ALU_OP_SUB,  32'd5,         32'd7,         4'd1,  32'hFFFF_FFFE};
    vecs[2]  = '{ALU_OP_SLL,  32'd1,         32'h21,        4'd2,  32'h0000_0002};
    vecs[3]  = '{ALU_OP_SLT,  32'hFFFF_FFFF, 32'd1,         4'd4,  32'h0000_0001};
    vecs[4]  = '{ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1,         4'd5,  32'h0000_0000};
    vecs[5]  = '{ALU_OP_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd6,  32'hFF00_FF00};
    vecs[6]  = '{ALU_OP_SRL,  32'h8000_0000, 32'd31,        4'd7,  32'h0000_0001};
    vecs[7]  = '{ALU_OP_SRA,  32'h8000_0000, 32'd31,        4'd8,  32'hFFFF_FFFF};
    vecs[8]  = '{ALU_OP_OR,   32'h0000_00F0, 32'h0000_0F00, 4'd9,  32'h0000_0FF0};
    vecs[9]  = '{ALU_OP_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 4'd10, 32'h0F00_0F00};
    vecs[10] = '{BR_OP_BEQ,   32'd5,         32'd5,         4'd11, 32'h0000_0001};
    vecs[11] = '{BR_OP_BNE,   32'd5,         32'd5,         4'd12, 32'h0000_0000};
    vecs[12] = '{BR_OP_BLT,   32'hFFFF_FFFF, 32'd1,         4'd13, 32'h0000_0001};
    vecs[13] = '{BR_OP_BGE,   32'hFFFF_FFFF, 32'd1,         4'd14, 32'h0000_0000};
    vecs[14] = '{BR_OP_BLTU,  32'hFFFF_FFFF, 32'd1,         4'd15, 32'h0000_0000};
    vecs[15] = '{BR_OP_BGEU,  32'hFFFF_FFFF, 32'd1,         4'd0,  32'h0000_0001};
    vecs[16] = '{ALU_OP_SRA,  32'h4000_0000, 32'h21,        4'd1,  32'h2000_0000};
    vecs[17] = '{ALU_OP_SRL,  32'h8000_0000, 32'h21,        4'd2,  32'h4000_0000};

    bus.flush = 1'b0; bus.in_req = 1'b0; bus.in_opc = ALU_OP_ADD;
    bus.in_src1 = '0; bus.in_src2 = '0; bus.in_tag = '0; bus.out_rdy = 1'b0;
    bus3.flush = 1'b0; bus3.in_req = 1'b0; bus3.in_opc = ALU_OP_ADD;
    bus3.in_src1 = '0; bus3.in_src2 = '0; bus3.in_tag = '0; bus3.out_rdy = 1'b0;

    // Reset state
    #3;
    check("rst_out_req", bus.out_req, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_out_wdata", bus.out_wdata, 0);
    check("rst_count", bus.count, 0);
    check("rst_in_rdy", bus.in_rdy, 1);
    @(negedge clk);
    rst = 1'b1;

    // Single op latency
    drive(ALU_OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'd3);
    @(negedge clk);
    check("single_out_req", bus.out_req, 1);
    check("single_out_tag", bus.out_tag, 3);
    check("single_out_wdata", bus.out_wdata, 0);
    check("single_count", bus.count, 1);
    bus.in_req = 1'b0; bus.out_rdy = 1'b1;
    @(negedge clk);
    check("single_drain_req", bus.out_req, 0);
    check("single_drain_count", bus.count, 0);

    // Opcode table, streamed one per cycle with the CDB always granting
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].tag);
      @(negedge clk);
      check($sformatf("vec%0d_req", i), bus.out_req, 1);
      check($sformatf("vec%0d_tag", i), bus.out_tag, vecs[i].tag);
      check($sformatf("vec%0d_wdata", i), bus.out_wdata, vecs[i].exp);
    end
    bus.in_req = 1'b0;
    @(negedge clk);
    check("vec_drain_count", bus.count, 0);

    // Backpressure fill, stall, then simultaneous push/pop while full
    bus.out_rdy = 1'b0;
    drive(ALU_OP_ADD, 32'd1, 32'd0, 4'd1);
    @(negedge clk);
    drive(ALU_OP_ADD, 32'd2, 32'd0, 4'd2);
    @(negedge clk);
    check("bp_full_count", bus.count, 2);
    check("bp_full_in_rdy", bus.in_rdy, 0);
    check("bp_full_head", bus.out_tag, 1);
    drive(ALU_OP_ADD, 32'd3, 32'd0, 4'd3);
    @(negedge clk);
    check("bp_stall_count", bus.count, 2);
    check("bp_stall_head", bus.out_tag, 1);
    bus.out_rdy = 1'b1;
    #1;
    check("bp_pushpop_in_rdy", bus.in_rdy, 1);
    @(negedge clk);
    check("bp_pushpop_count", bus.count, 2);
    check("bp_order_2", bus.out_tag, 2);
    bus.in_req = 1'b0;
    @(negedge clk);
    check("bp_order_3", bus.out_tag, 3);
    check("bp_order_3_data", bus.out_wdata, 3);
    check("bp_order_3_count", bus.count, 1);
    @(negedge clk);
    check("bp_empty_req", bus.out_req, 0);

    // Flush while full with grant and request active
    bus.out_rdy = 1'b0;
    drive(ALU_OP_ADD, 32'd6, 32'd0, 4'd6);
    @(negedge clk);
    drive(ALU_OP_ADD, 32'd7, 32'd0, 4'd7);
    @(negedge clk);
    check("fl_pre_count", bus.count, 2);
    bus.flush = 1'b1; bus.out_rdy = 1'b1;
    drive(ALU_OP_ADD, 32'd8, 32'd0, 4'd8);
    #1;
    check("fl_out_req", bus.out_req, 0);
    check("fl_in_rdy", bus.in_rdy, 0);
    @(negedge clk);
    bus.flush = 1'b0; bus.in_req = 1'b0;
    #1;
    check("fl_post_count", bus.count, 0);
    check("fl_post_req", bus.out_req, 0);
    @(negedge clk);
    check("fl_no_tag8", bus.out_req, 0);

    // Async reset mid-stream
    bus.out_rdy = 1'b0;
    drive(ALU_OP_ADD, 32'd9, 32'd0, 4'd9);
    @(negedge clk);
    drive(ALU_OP_ADD, 32'd10, 32'd0, 4'd10);
    @(negedge clk);
    bus.in_req = 1'b0;
    check("ar_pre_count", bus.count, 2);
    rst = 1'b0;
    #1;
    check("ar_out_req", bus.out_req, 0);
    check("ar_count", bus.count, 0);
    check("ar_out_tag", bus.out_tag, 0);
    #1;
    rst = 1'b1;
    @(negedge clk);
    drive(ALU_OP_ADD, 32'd5, 32'd0, 4'd5);
    @(negedge clk);
    check("ar_push_tag", bus.out_tag, 5);
    check("ar_push_count", bus.count, 1);
    bus.in_req = 1'b0; bus.out_rdy = 1'b1;
    @(negedge clk);
    check("ar_alone_req", bus.out_req, 0);
    bus.out_rdy = 1'b0;

    // Random streaming on DEPTH=3 against a queue scoreboard
    for (int c = 0; c < 400; c++) begin
      logic m_req, m_rdy;
      bus3.in_req  = ($urandom_range(0, 3) != 0);
      bus3.in_opc  = exu_opc_t'($urandom_range(0, 15));
      bus3.in_src1 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      bus3.in_src2 = ($urandom_range(0, 3) == 0) ? bus3.in_src1 : $urandom;
      bus3.in_tag  = 4'($urandom_range(0, 15));
      bus3.out_rdy = ($urandom_range(0, 2) != 0);
      bus3.flush   = ($urandom_range(0, 23) == 0);
      #1;
      m_req = (sb.size() != 0) && !bus3.flush;
      m_rdy = ((sb.size() != 3) || (bus3.out_rdy && sb.size() != 0)) && !bus3.flush;
      check("rnd_count", bus3.count, sb.size());
      check("rnd_out_req", bus3.out_req, m_req);
      check("rnd_in_rdy", bus3.in_rdy, m_rdy);
      if (m_req) begin
        check("rnd_tag", bus3.out_tag, sb[0].tag);
        check("rnd_wdata", bus3.out_wdata, sb[0].wdata);
      end
      if (bus3.flush) sb.delete();
      else begin
        if (m_req && bus3.out_rdy) void'(sb.pop_front());
        if (m_rdy && bus3.in_req)
          sb.push_back('{bus3.in_tag, ref_alu(bus3.in_opc, bus3.in_src1, bus3.in_src2)});
      end
      @(negedge clk);
    end
    bus3.in_req = 1'b0; bus3.flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
